// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares one single-port 16-bit word memory between the core's instruction
// fetch port (opcode + prefetch opcode) and its byte-lane data port.
// Data accesses have priority; a run counter bounds how many data grants may
// be issued while an instruction fetch is outstanding.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no memory transfer; arbitrate between pending data op and fetch
//   F_PC  | reading the word at the latched pc tag
//   F_PF  | reading the word at the latched prefetch tag
//   DATA  | performing the core's data read or write
module unified_mem_arbiter #(
   parameter int MAX_DATA_RUN = 4
) (
   input  logic        clk,
   input  logic        a_rst,
   // instruction port
   input  logic [15:0] i_mem_pc,
   input  logic [15:0] i_mem_prefetch,
   output logic [15:0] i_mem_opcode,
   output logic [15:0] i_mem_prefetch_opcode,
   output logic        i_mem_rdy,
   // data port
   input  logic        d_mem_assert,
   input  logic        d_mem_cmd,
   input  logic [15:0] d_mem_addr,
   input  logic        d_mem_be0,
   input  logic        d_mem_be1,
   input  logic [15:0] d_mem_data_out,
   output logic [15:0] d_mem_data_in,
   output logic        d_mem_rdy,
   // memory port
   output logic        m_req,
   output logic        m_we,
   output logic [14:0] m_addr,
   output logic [1:0]  m_be,
   output logic [15:0] m_wdata,
   input  logic [15:0] m_rdata,
   input  logic        m_ack
);

   localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);
   localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      F_PC = 2'd1,
      F_PF = 2'd2,
      DATA = 2'd3
   } state_t;

   state_t           r_state;
   logic [14:0]      r_pc_tag;
   logic [14:0]      r_pf_tag;
   logic             r_fetch_valid;
   logic [RUN_W-1:0] r_run;

   logic [14:0]      w_pc_word;
   logic [14:0]      w_pf_word;
   logic             w_fetch_hit;
   logic             w_miss;
   logic             w_data_pend;
   logic             w_run_sat;
   logic             w_data_grant;
   logic [RUN_W-1:0] w_run_next;
   logic             w_wr_hits_code;
   logic [15:0]      w_rd_lanes;
   logic             w_unused;

   // Byte bit 0 of every address is don't-care: the memory is word organised.
   assign w_unused    = ^{i_mem_pc[0], i_mem_prefetch[0], d_mem_addr[0]};

   // Fetch hit/miss against the tags of the last started fetch.
   assign w_pc_word   = i_mem_pc[15:1];
   assign w_pf_word   = i_mem_prefetch[15:1];
   assign w_fetch_hit = r_fetch_valid
                        & (r_pc_tag == w_pc_word)
                        & (r_pf_tag == w_pf_word);
   assign w_miss      = ~w_fetch_hit;
   assign i_mem_rdy   = w_fetch_hit;

   // The d_mem_rdy cycle still sees the old request held, so it is masked.
   assign w_data_pend  = d_mem_assert & ~d_mem_rdy;
   assign w_run_sat    = (r_run >= RUN_MAX);
   assign w_data_grant = w_data_pend & (~w_miss | ~w_run_sat);

   // Count data grants only while a fetch is waiting; saturate at the limit.
   always_comb begin
      w_run_next = '0;
      if (w_miss) begin
         w_run_next = w_run_sat ? RUN_MAX : (r_run + RUN_ONE);
      end
   end

   // A data write landing on either fetched word invalidates the opcodes.
   assign w_wr_hits_code = m_we & ((m_addr == r_pc_tag) | (m_addr == r_pf_tag));

   // Read data with disabled lanes forced to zero.
   assign w_rd_lanes = {m_be[1] ? m_rdata[15:8] : 8'h00,
                        m_be[0] ? m_rdata[7:0]  : 8'h00};

   // Arbitration FSM with registered memory-port and core-side outputs.
   always_ff @(posedge clk) begin
      if (a_rst) begin
         r_state               <= IDLE;
         r_pc_tag              <= '0;
         r_pf_tag              <= '0;
         r_fetch_valid         <= 1'b0;
         r_run                 <= '0;
         i_mem_opcode          <= '0;
         i_mem_prefetch_opcode <= '0;
         d_mem_data_in         <= '0;
         d_mem_rdy             <= 1'b0;
         m_req                 <= 1'b0;
         m_we                  <= 1'b0;
         m_addr                <= '0;
         m_be                  <= '0;
         m_wdata               <= '0;
      end else begin
         d_mem_rdy <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_data_grant) begin
                  r_state <= DATA;
                  r_run   <= w_run_next;
                  m_req   <= 1'b1;
                  m_we    <= d_mem_cmd;
                  m_be    <= {d_mem_be1, d_mem_be0};
                  m_addr  <= d_mem_addr[15:1];
                  m_wdata <= d_mem_data_out;
               end else if (w_miss) begin
                  r_state       <= F_PC;
                  r_pc_tag      <= w_pc_word;
                  r_pf_tag      <= w_pf_word;
                  r_fetch_valid <= 1'b0;
                  r_run         <= '0;
                  m_req         <= 1'b1;
                  m_we          <= 1'b0;
                  m_be          <= 2'b11;
                  m_addr        <= w_pc_word;
               end else begin
                  m_req <= 1'b0;
               end
            end

            DATA: begin
               if (m_ack) begin
                  d_mem_rdy <= 1'b1;
                  if (!m_we) begin
                     d_mem_data_in <= w_rd_lanes;
                  end
                  if (w_wr_hits_code) begin
                     r_fetch_valid <= 1'b0;
                  end
                  m_req   <= 1'b0;
                  m_we    <= 1'b0;
                  r_state <= IDLE;
               end
            end

            F_PC: begin
               if (m_ack) begin
                  i_mem_opcode <= m_rdata;
                  if (r_pf_tag == r_pc_tag) begin
                     // Both opcodes live in one word: a single read serves both.
                     i_mem_prefetch_opcode <= m_rdata;
                     r_fetch_valid         <= 1'b1;
                     m_req                 <= 1'b0;
                     r_state               <= IDLE;
                  end else begin
                     m_addr  <= r_pf_tag;
                     r_state <= F_PF;
                  end
               end
            end

            F_PF: begin
               if (m_ack) begin
                  i_mem_prefetch_opcode <= m_rdata;
                  r_fetch_valid         <= 1'b1;
                  m_req                 <= 1'b0;
                  r_state               <= IDLE;
               end
            end

            default: begin
               m_req   <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a word memory model and
// expected-result queues for data reads and instruction fetches.
module tb_unified_mem_arbiter;

   logic        clk;
   logic        a_rst;
   logic [15:0] i_mem_pc;
   logic [15:0] i_mem_prefetch;
   logic [15:0] i_mem_opcode;
   logic [15:0] i_mem_prefetch_opcode;
   logic        i_mem_rdy;
   logic        d_mem_assert;
   logic        d_mem_cmd;
   logic [15:0] d_mem_addr;
   logic        d_mem_be0;
   logic        d_mem_be1;
   logic [15:0] d_mem_data_out;
   logic [15:0] d_mem_data_in;
   logic        d_mem_rdy;
   logic        m_req;
   logic        m_we;
   logic [14:0] m_addr;
   logic [1:0]  m_be;
   logic [15:0] m_wdata;
   logic [15:0] m_rdata;
   logic        m_ack;

   unified_mem_arbiter #(.MAX_DATA_RUN(4)) dut (
      .clk                   (clk),
      .a_rst                 (a_rst),
      .i_mem_pc              (i_mem_pc),
      .i_mem_prefetch        (i_mem_prefetch),
      .i_mem_opcode          (i_mem_opcode),
      .i_mem_prefetch_opcode (i_mem_prefetch_opcode),
      .i_mem_rdy             (i_mem_rdy),
      .d_mem_assert          (d_mem_assert),
      .d_mem_cmd             (d_mem_cmd),
      .d_mem_addr            (d_mem_addr),
      .d_mem_be0             (d_mem_be0),
      .d_mem_be1             (d_mem_be1),
      .d_mem_data_out        (d_mem_data_out),
      .d_mem_data_in         (d_mem_data_in),
      .d_mem_rdy             (d_mem_rdy),
      .m_req                 (m_req),
      .m_we                  (m_we),
      .m_addr                (m_addr),
      .m_be                  (m_be),
      .m_wdata               (m_wdata),
      .m_rdata               (m_rdata),
      .m_ack                 (m_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory model
   logic [15:0] mem [0:32767];
   logic        pl_en;
   logic [14:0] pl_addr;
   logic [15:0] pl_data;
   logic        ack_tied;
   int          ack_wait;
   int          ack_cnt;
   int          n_xfer;

   always_comb m_rdata = mem[m_addr];
   always_comb m_ack   = ack_tied ? 1'b1 : (m_req && (ack_cnt == ack_wait));

   always @(posedge clk) begin
      if (pl_en) begin
         mem[pl_addr] <= pl_data;
      end else if (m_req && m_ack && m_we) begin
         if (m_be[0]) mem[m_addr][7:0]  <= m_wdata[7:0];
         if (m_be[1]) mem[m_addr][15:8] <= m_wdata[15:8];
      end
      if (m_req && m_ack) n_xfer <= n_xfer + 1;
      if (!m_req || m_ack) ack_cnt <= 0;
      else                 ack_cnt <= ack_cnt + 1;
   end

   // scoreboards
   logic [15:0] dq[$];
   logic [31:0] fq[$];
   int n_cmp = 0;
   int n_err = 0;
   logic ir_at_rdy;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [14:0] a, input logic [15:0] d);
      pl_addr = a;
      pl_data = d;
      pl_en   = 1'b1;
      @(negedge clk);
      pl_en   = 1'b0;
   endtask

   task automatic wait_irdy(input string tag, input int max, output int lat);
      lat = -1;
      for (int i = 1; i <= max; i++) begin
         @(negedge clk);
         if (i_mem_rdy) begin
            lat = i;
            break;
         end
      end
      chk({tag, "_rdy"}, 32'(lat > 0), 32'd1);
      if (lat > 0 && fq.size() > 0)
         chk({tag, "_op"}, {i_mem_opcode, i_mem_prefetch_opcode}, fq.pop_front());
   endtask

   task automatic do_data(input string tag, input logic cmd, input logic [15:0] addr,
                          input logic [1:0] be, input logic [15:0] wd, input logic [15:0] exp,
                          input int exp_lat, input int exp_we);
      int lat;
      int nwe;
      if (!cmd) dq.push_back(exp);
      d_mem_cmd      = cmd;
      d_mem_addr     = addr;
      {d_mem_be1, d_mem_be0} = be;
      d_mem_data_out = wd;
      d_mem_assert   = 1'b1;
      lat = -1;
      nwe = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (m_req && m_we && m_be == 2'b11) nwe++;
         if (d_mem_rdy) begin
            lat = i;
            ir_at_rdy = i_mem_rdy;
            break;
         end
      end
      d_mem_assert = 1'b0;
      chk({tag, "_lat"}, lat, exp_lat);
      if (!cmd && lat > 0 && dq.size() > 0) chk({tag, "_rdata"}, {16'h0, d_mem_data_in}, {16'h0, dq.pop_front()});
      if (cmd) chk({tag, "_we_cycles"}, nwe, exp_we);
      @(negedge clk);
      chk({tag, "_pulse"}, {31'h0, d_mem_rdy}, 32'd0);
   endtask

   initial begin
      int lat;
      int nreq;
      int n0;
      int ndata;
      int nbefore;
      logic fseen;
      logic found;

      a_rst = 1'b1;
      i_mem_pc = 16'h0002;
      i_mem_prefetch = 16'h0004;
      d_mem_assert = 1'b0;
      d_mem_cmd = 1'b0;
      d_mem_addr = 16'h0;
      d_mem_be0 = 1'b0;
      d_mem_be1 = 1'b0;
      d_mem_data_out = 16'h0;
      ack_tied = 1'b1;
      ack_wait = 0;
      pl_en = 1'b0;
      pl_addr = '0;
      pl_data = '0;
      n_xfer = 0;
      ir_at_rdy = 1'b0;

      @(negedge clk);
      preload(15'h0001, 16'h1790);
      preload(15'h0002, 16'h0000);
      preload(15'h0008, 16'hABCD);
      preload(15'h0010, 16'h5A5A);
      preload(15'h0050, 16'hC0DE);
      preload(15'h0051, 16'h7777);

      chk("rst_ctl", {27'h0, m_req, m_we, d_mem_rdy, i_mem_rdy, m_be == 2'b00}, 32'h1);
      chk("rst_ops", {i_mem_opcode, i_mem_prefetch_opcode}, 32'h0);

      // 1: first fetch after reset, two different words
      fq.push_back({16'h1790, 16'h0000});
      a_rst = 1'b0;
      wait_irdy("t1", 20, lat);
      chk("t1_lat", lat, 3);

      // 2: pc and prefetch in the same word -> one memory read
      n0 = n_xfer;
      nreq = 0;
      i_mem_pc = 16'h0010;
      i_mem_prefetch = 16'h0010;
      fq.push_back({16'hABCD, 16'hABCD});
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (m_req) nreq++;
         if (i_mem_rdy) begin
            lat = i;
            break;
         end
      end
      chk("t2_lat", lat, 2);
      chk("t2_req_cycles", nreq, 1);
      chk("t2_xfers", n_xfer - n0, 1);
      if (lat > 0) chk("t2_op", {i_mem_opcode, i_mem_prefetch_opcode}, fq.pop_front());

      // 3: byte-lane reads
      do_data("t3_lo", 1'b0, 16'h00A0, 2'b01, 16'h0, 16'h00DE, 2, 0);
      do_data("t3_hi", 1'b0, 16'h00A0, 2'b10, 16'h0, 16'hC000, 2, 0);

      // 4: write with three wait states, then read back
      ack_tied = 1'b0;
      ack_wait = 3;
      do_data("t4_wr", 1'b1, 16'h00A2, 2'b11, 16'hB000, 16'h0, 5, 4);
      chk("t4_code_kept", {31'h0, i_mem_rdy}, 32'd1);
      do_data("t4_rd", 1'b0, 16'h00A2, 2'b11, 16'h0, 16'hB000, 5, 0);

      // write into the fetched word invalidates the opcodes and forces a refetch
      do_data("wc_wr", 1'b1, 16'h0010, 2'b11, 16'h1234, 16'h0, 5, 4);
      chk("wc_inval", {31'h0, ir_at_rdy}, 32'd0);
      fq.push_back({16'h1234, 16'h1234});
      wait_irdy("wc", 40, lat);

      // 5: continuous data requests against a pending fetch miss
      ack_tied = 1'b1;
      ndata = 0;
      nbefore = -1;
      fseen = 1'b0;
      found = 1'b0;
      i_mem_pc = 16'h0020;
      i_mem_prefetch = 16'h0020;
      fq.push_back({16'h5A5A, 16'h5A5A});
      d_mem_cmd = 1'b0;
      d_mem_addr = 16'h00A0;
      {d_mem_be1, d_mem_be0} = 2'b11;
      d_mem_assert = 1'b1;
      dq.push_back(16'hC0DE);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (m_req && !m_we && m_addr == 15'h0010 && !fseen) begin
            fseen = 1'b1;
            nbefore = ndata;
         end
         if (d_mem_rdy) begin
            ndata++;
            if (dq.size() > 0) chk("t5_rdata", {16'h0, d_mem_data_in}, {16'h0, dq.pop_front()});
            if (fseen) d_mem_assert = 1'b0;
            else       dq.push_back(16'hC0DE);
         end
         if (fseen && !d_mem_assert && i_mem_rdy) begin
            found = 1'b1;
            break;
         end
      end
      d_mem_assert = 1'b0;
      chk("t5_done", {31'h0, found}, 32'd1);
      chk("t5_bound", 32'(nbefore >= 1 && nbefore <= 4), 32'd1);
      if (found && fq.size() > 0) chk("t5_op", {i_mem_opcode, i_mem_prefetch_opcode}, fq.pop_front());

      // 6: reset while waiting in F_PF, then clean refetch
      ack_tied = 1'b0;
      ack_wait = 2;
      i_mem_pc = 16'h0002;
      i_mem_prefetch = 16'h0004;
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (m_req && !m_we && m_addr == 15'h0002) begin
            found = 1'b1;
            break;
         end
      end
      chk("t6_in_fpf", {30'h0, found, m_ack}, 32'h2);
      a_rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_ctl", {11'h0, m_req, m_we, m_addr, m_be, d_mem_rdy, i_mem_rdy}, 32'h0);
      chk("t6_rst_ops", {i_mem_opcode, i_mem_prefetch_opcode}, 32'h0);
      chk("t6_rst_data", {m_wdata, d_mem_data_in}, 32'h0);
      a_rst = 1'b0;
      n0 = n_xfer;
      fq.push_back({16'h1790, 16'h0000});
      wait_irdy("t6", 40, lat);
      chk("t6_xfers", n_xfer - n0, 2);

      chk("sb_empty", dq.size() + fq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
